// File: rtl/memoria_principal.sv
// Main memory behind the cache: 32 x 5-bit words with write-back and refill phases of LATENCIA cycles.
// Optional access statistics ports are enabled with the MEMORIA_ESTATISTICA_EN macro.
module memoria_principal #(
    parameter int unsigned LATENCIA = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       solicitacao_de_leitura,
    input  logic       solicitacao_de_escrita,
    input  logic [4:0] endereco_leitura,
    input  logic [4:0] endereco_escrita,
    input  logic [4:0] dado_escrita,
    output logic [4:0] dado_lido,
    output logic       pronto,
    output logic       ocupado
`ifdef MEMORIA_ESTATISTICA_EN
    ,
    output logic [7:0] conta_leituras,
    output logic [7:0] conta_escritas
`endif
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 5;
    localparam int unsigned NW = 32;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESCRITA  = 2'd1,
        LEITURA  = 2'd2,
        RESPOSTA = 2'd3
    } estado_t;

    estado_t        estado_q, estado_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pend_q, pend_d;
    logic [AW-1:0]  ra_q, ra_d;
    logic [AW-1:0]  wa_q, wa_d;
    logic [DW-1:0]  wd_q, wd_d;
    logic [DW-1:0]  dado_q, dado_d;
    logic           pronto_q, pronto_d;
    logic           ocupado_q, ocupado_d;
    logic           grava_c;
    logic [DW-1:0]  mem_q [NW];

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q  <= OCIOSO;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            ra_q      <= '0;
            wa_q      <= '0;
            wd_q      <= '0;
            dado_q    <= '0;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            ra_q      <= ra_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            dado_q    <= dado_d;
            pronto_q  <= pronto_d;
            ocupado_q <= ocupado_d;
        end
    end

    // Next-state logic; a combined request runs the write phase first so a same-address read sees new data
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        ra_d     = ra_q;
        wa_d     = wa_q;
        wd_d     = wd_q;
        dado_d   = dado_q;
        grava_c  = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (solicitacao_de_escrita || solicitacao_de_leitura) begin
                    estado_d = solicitacao_de_escrita ? ESCRITA : LEITURA;
                    cnt_d    = CW'(LATENCIA - 1);
                    pend_d   = solicitacao_de_escrita && solicitacao_de_leitura;
                    ra_d     = endereco_leitura;
                    wa_d     = endereco_escrita;
                    wd_d     = dado_escrita;
                end
            end
            ESCRITA: begin
                if (cnt_q == '0) begin
                    grava_c = 1'b1;
                    if (pend_q) begin
                        estado_d = LEITURA;
                        cnt_d    = CW'(LATENCIA - 1);
                        pend_d   = 1'b0;
                    end else begin
                        estado_d = RESPOSTA;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LEITURA: begin
                if (cnt_q == '0) begin
                    dado_d   = mem_q[ra_q];
                    estado_d = RESPOSTA;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESPOSTA: estado_d = OCIOSO;
            default:  estado_d = OCIOSO;
        endcase
        pronto_d  = (estado_d == RESPOSTA);
        ocupado_d = (estado_d != OCIOSO);
    end

    // Storage array; reset loads each word with its own address
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NW; i++) begin
                mem_q[i] <= DW'(i);
            end
        end else if (grava_c) begin
            mem_q[wa_q] <= wd_q;
        end
    end

    assign dado_lido = dado_q;
    assign pronto    = pronto_q;
    assign ocupado   = ocupado_q;

`ifdef MEMORIA_ESTATISTICA_EN
    logic [7:0] leit_q, escr_q;
    logic       le_c;

    assign le_c = (estado_q == LEITURA) && (cnt_q == '0);

    // Saturating counters of committed accesses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            leit_q <= '0;
            escr_q <= '0;
        end else begin
            if (le_c && (leit_q != 8'hFF)) leit_q <= leit_q + 8'd1;
            if (grava_c && (escr_q != 8'hFF)) escr_q <= escr_q + 8'd1;
        end
    end

    assign conta_leituras = leit_q;
    assign conta_escritas = escr_q;
`endif

endmodule

// File: tb/tb_memoria_principal.sv
// Randomized bench for memoria_principal against an array-based transaction model.
module tb_memoria_principal;

    localparam int unsigned LAT = 2;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rd_req, wr_req;
    logic [4:0] ra, wa, wd;
    logic [4:0] dado_lido;
    logic       pronto, ocupado;
`ifdef MEMORIA_ESTATISTICA_EN
    logic [7:0] conta_leituras, conta_escritas;
`endif

    memoria_principal #(.LATENCIA(LAT)) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .solicitacao_de_leitura (rd_req),
        .solicitacao_de_escrita (wr_req),
        .endereco_leitura       (ra),
        .endereco_escrita       (wa),
        .dado_escrita           (wd),
        .dado_lido              (dado_lido),
        .pronto                 (pronto),
        .ocupado                (ocupado)
`ifdef MEMORIA_ESTATISTICA_EN
        ,
        .conta_leituras         (conta_leituras),
        .conta_escritas         (conta_escritas)
`endif
    );

    always #5 clock = ~clock;

    int         n_vec = 0;
    int         n_err = 0;
    logic [4:0] mem_m [32];
    logic [4:0] dado_m;
    int         cl_m, ce_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 32; i++) mem_m[i] = 5'(i);
        dado_m = 5'd0;
        cl_m   = 0;
        ce_m   = 0;
    endtask

    task automatic clear_inputs();
        rd_req = 1'b0;
        wr_req = 1'b0;
        ra     = 5'd0;
        wa     = 5'd0;
        wd     = 5'd0;
    endtask

    // One transaction; ocupado/pronto/dado_lido checked every cycle until back in idle
    task automatic txn(input bit rd, input bit wr, input logic [4:0] a_r,
                       input logic [4:0] a_w, input logic [4:0] d_w, input bit junk);
        int n;
        n = int'(LAT) * (int'(rd) + int'(wr));
        @(negedge clock);
        rd_req = rd;
        wr_req = wr;
        ra     = a_r;
        wa     = a_w;
        wd     = d_w;
        @(posedge clock);
        if (wr) begin
            mem_m[a_w] = d_w;
            if (ce_m < 255) ce_m++;
        end
        if (rd) begin
            dado_m = mem_m[a_r];
            if (cl_m < 255) cl_m++;
        end
        for (int k = 0; k <= n + 1; k++) begin
            if (k > 0) @(posedge clock);
            #1;
            chk("ocupado", 32'(ocupado), 32'(k <= n));
            chk("pronto", 32'(pronto), 32'(k == n));
            if (k >= n) chk("dado_lido", 32'(dado_lido), 32'(dado_m));
            if (junk && k < n) begin
                rd_req = 1'($urandom);
                wr_req = 1'($urandom);
                ra     = 5'($urandom);
                wa     = 5'($urandom);
                wd     = 5'($urandom);
            end else begin
                clear_inputs();
            end
        end
    endtask

    initial begin
        bit         rr, ww;
        logic [4:0] a1, a2, d1;
        reset_n = 1'b0;
        clear_inputs();
        reset_model();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_pronto", 32'(pronto), 32'd0);
        chk("rst_dado", 32'(dado_lido), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed cases
        txn(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0);
        txn(1'b0, 1'b1, 5'd0, 5'd3, 5'h1F, 1'b0);
        txn(1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0);
        txn(1'b1, 1'b1, 5'd9, 5'd4, 5'h0A, 1'b0);
        txn(1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 1'b0);
        txn(1'b1, 1'b1, 5'd12, 5'd12, 5'h15, 1'b0);
        txn(1'b0, 1'b1, 5'd0, 5'd20, 5'h02, 1'b1);

        // Reset in the middle of a write: aborted, nothing committed, no pronto
        @(negedge clock);
        wr_req = 1'b1;
        wa     = 5'd6;
        wd     = 5'h00;
        @(posedge clock);
        #1;
        clear_inputs();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_ocupado", 32'(ocupado), 32'd0);
        chk("abort_pronto", 32'(pronto), 32'd0);
        chk("abort_dado", 32'(dado_lido), 32'd0);
        reset_model();
        @(posedge clock);
        #1;
        chk("abort_pronto_edge", 32'(pronto), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        txn(1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 1'b0);

        // Randomized traffic, with junk requests while busy
        for (int t = 0; t < 60; t++) begin
            rr = 1'($urandom);
            ww = 1'($urandom);
            if (!rr && !ww) rr = 1'b1;
            a1 = 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom);
            d1 = 5'($urandom);
            txn(rr, ww, a1, a2, d1, 1'($urandom));
        end

`ifdef MEMORIA_ESTATISTICA_EN
        @(negedge clock);
        reset_n = 1'b0;
        reset_model();
        @(negedge clock);
        reset_n = 1'b1;
        for (int t = 0; t < 300; t++) txn(1'b1, 1'b0, 5'($urandom), 5'd0, 5'd0, 1'b0);
        chk("conta_leituras", 32'(conta_leituras), 32'(cl_m));
        chk("conta_escritas", 32'(conta_escritas), 32'(ce_m));
        chk("conta_leituras_sat", 32'(conta_leituras), 32'd255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memoria_principal.md
MEMORIA_PRINCIPAL -- requirements
Module: memoria_principal

Interface
REQ-001 Parameter LATENCIA, default 2, cycles per memory phase, legal range 1..15.
REQ-002 clock  input  1  sole clock, all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 solicitacao_de_leitura  input  1  cache requests block refill.
REQ-005 solicitacao_de_escrita  input  1  cache requests dirty-block write-back.
REQ-006 endereco_leitura  input  5  word address for refill.
REQ-007 endereco_escrita  input  5  word address for write-back (victim tag+index).
REQ-008 dado_escrita  input  5  block data to write back.
REQ-009 dado_lido  output  5  refill data, valid while pronto=1, held afterwards.
REQ-010 pronto  output  1  one-cycle pulse, transaction complete.
REQ-011 ocupado  output  1  high while a transaction is in progress; requests ignored.

Function
REQ-012 Storage: 32 words x 5 bits, internal array.
REQ-013 FSM states: OCIOSO, ESCRITA, LEITURA, RESPOSTA.
REQ-014 Requests sampled only in OCIOSO; inputs ignored in all other states.
REQ-015 In OCIOSO at edge E0: write-only -> ESCRITA; read-only -> LEITURA; both -> ESCRITA with read pending; addresses and dado_escrita latched at E0.
REQ-016 On entering ESCRITA or LEITURA, phase counter loads LATENCIA-1; decrements each edge.
REQ-017 ESCRITA with counter=0 at edge: latched data committed to latched write address; next state LEITURA if read pending (counter reloaded), else RESPOSTA.
REQ-018 LEITURA with counter=0 at edge: dado_lido registered from latched read address; next state RESPOSTA.
REQ-019 RESPOSTA: pronto=1 for exactly one cycle; next edge -> OCIOSO.
REQ-020 Latency: single op pronto high in cycle after edge E0+LATENCIA; combined op after E0+2*LATENCIA.
REQ-021 ocupado=1 in ESCRITA, LEITURA, RESPOSTA; 0 only in OCIOSO.
REQ-022 Combined op with equal addresses: read returns newly written data.
REQ-023 Write-only transaction leaves dado_lido unchanged.
REQ-024 Back-to-back: request held through RESPOSTA is accepted at the first edge in OCIOSO (one idle cycle between transactions).

Reset
REQ-025 reset_n=0 forces, without clock: state OCIOSO, pronto=0, ocupado=0, dado_lido=0, counter=0, pending flag cleared.
REQ-026 Reset initialises memory word i to value i (i=0..31).
REQ-027 Reset mid-transaction aborts it; an uncommitted write is discarded, no pronto issued.
REQ-028 First request accepted at the first rising edge after reset_n deasserts.

Configuration
REQ-029 Macro MEMORIA_ESTATISTICA_EN defined: outputs conta_leituras[7:0] and conta_escritas[7:0] added, reset to 0, incremented at each committed read/write, saturating at 255.
REQ-030 Macro undefined: those ports and counters absent; all other behaviour identical.

Verification (LATENCIA=2)
REQ-031 After reset, read address 7 at E0 -> pronto pulse after E0+2, dado_lido=7, ocupado 1 for 3 cycles.
REQ-032 Write 5'h1F to address 3, then read address 3 -> dado_lido=5'h1F.
REQ-033 Both requests, write address 4 data 5'h0A, read address 9 -> single pronto after E0+4, dado_lido=9, mem[4]=5'h0A.
REQ-034 Both requests to address 12, data 5'h15 -> dado_lido=5'h15.
REQ-035 reset_n low one cycle into ESCRITA of write 5'h00 to address 6 -> no pronto, mem[6]=6, ocupado=0 immediately.
REQ-036 With MEMORIA_ESTATISTICA_EN, 300 reads -> conta_leituras=255, conta_escritas=0.
